// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, clock deglitch filter, 11-bit
// frame deframer with odd parity, and keyboard prefix (E0/F0) folding.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_rcv,
  input  logic       kb_or_mouse,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       kb_interrupt,
  output logic [7:0] scancode,
  output logic       released,
  output logic       extended,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          fclk_q, fclk_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;

  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tocnt_q, tocnt_d;
  logic          ext_flag_q, ext_flag_d;
  logic          rel_flag_q, rel_flag_d;

  logic          kb_int_q, kb_int_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    code_q, code_d;
  logic          rel_q, rel_d;
  logic          ext_q, ext_d;
  logic          accept;

  // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_s1_d = ps2clk_ext;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2data_ext;
    dat_s2_d = dat_s1_q;
    fclk_d   = fclk_q;
    fcnt_d   = '0;
    fall_d   = 1'b0;
    if (clk_s2_q != fclk_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        fclk_d = clk_s2_q;
        fall_d = fclk_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tocnt_d    = tocnt_q;
    ext_flag_d = ext_flag_q;
    rel_flag_d = rel_flag_q;
    kb_int_d   = 1'b0;
    ferr_d     = 1'b0;
    code_d     = code_q;
    rel_d      = rel_q;
    ext_d      = ext_q;
    accept     = 1'b0;

    if (!enable_rcv) begin
      state_d    = S_IDLE;
      tocnt_d    = '0;
      ext_flag_d = 1'b0;
      rel_flag_d = 1'b0;
    end else begin
      if (kb_or_mouse) begin
        ext_flag_d = 1'b0;
        rel_flag_d = 1'b0;
      end
      // Timeout beats a coincident falling edge; prefix flags survive it.
      if (state_q != S_IDLE && tocnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        tocnt_d = '0;
        ferr_d  = 1'b1;
      end else begin
        tocnt_d = (state_q == S_IDLE) ? '0 : tocnt_q + 1'b1;
        if (fall_q) begin
          tocnt_d = '0;
          case (state_q)
            S_IDLE: begin
              if (!dat_s2_q) begin
                state_d  = S_DATA;
                bitcnt_d = '0;
              end else begin
                ferr_d = 1'b1;
              end
            end
            S_DATA: begin
              shift_d  = {dat_s2_q, shift_q[7:1]};
              bitcnt_d = bitcnt_q + 1'b1;
              if (bitcnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
              par_d   = dat_s2_q;
              state_d = S_STOP;
            end
            S_STOP: begin
              state_d = S_IDLE;
              if (dat_s2_q && ((^shift_q) ^ par_q)) accept = 1'b1;
              else                                   ferr_d = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      if (accept) begin
        if (kb_or_mouse) begin
          kb_int_d = 1'b1;
          code_d   = shift_q;
          rel_d    = 1'b0;
          ext_d    = 1'b0;
        end else if (shift_q == 8'hE0) begin
          ext_flag_d = 1'b1;
        end else if (shift_q == 8'hF0) begin
          rel_flag_d = 1'b1;
        end else begin
          kb_int_d   = 1'b1;
          code_d     = shift_q;
          rel_d      = rel_flag_q;
          ext_d      = ext_flag_q;
          ext_flag_d = 1'b0;
          rel_flag_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      fclk_q     <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tocnt_q    <= '0;
      ext_flag_q <= 1'b0;
      rel_flag_q <= 1'b0;
      kb_int_q   <= 1'b0;
      ferr_q     <= 1'b0;
      code_q     <= '0;
      rel_q      <= 1'b0;
      ext_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      fclk_q     <= fclk_d;
      fcnt_q     <= fcnt_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tocnt_q    <= tocnt_d;
      ext_flag_q <= ext_flag_d;
      rel_flag_q <= rel_flag_d;
      kb_int_q   <= kb_int_d;
      ferr_q     <= ferr_d;
      code_q     <= code_d;
      rel_q      <= rel_d;
      ext_q      <= ext_d;
    end
  end

  assign kb_interrupt = kb_int_q;
  assign frame_error  = ferr_q;
  assign scancode     = code_q;
  assign released     = rel_q;
  assign extended     = ext_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomised PS/2 frame stimulus scored against a byte-level keyboard/mouse model.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;
  localparam int FL = 8;
  localparam int TO = 2000;
  localparam int H  = 30;

  logic       clk = 1'b0;
  logic       rst_n, enable_rcv, kb_or_mouse, ps2clk_ext, ps2data_ext;
  logic       kb_interrupt, released, extended, frame_error;
  logic [7:0] scancode;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable_rcv(enable_rcv), .kb_or_mouse(kb_or_mouse),
    .ps2clk_ext(ps2clk_ext), .ps2data_ext(ps2data_ext), .kb_interrupt(kb_interrupt),
    .scancode(scancode), .released(released), .extended(extended),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  int cyc = 0, err_cnt = 0, exp_err = 0, last_err_cyc = 0, t_fall = 0;
  logic kb_prev = 1'b0, fe_prev = 1'b0;
  logic [9:0] act_q[$], exp_q[$];
  bit ef = 0, rf = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (kb_interrupt) begin
      act_q.push_back({scancode, released, extended});
      chk("kb_width", kb_prev, 0);
      chk("kb_fe_excl", frame_error, 0);
    end
    if (frame_error) begin
      err_cnt++;
      last_err_cyc = cyc;
      chk("fe_width", fe_prev, 0);
    end
    kb_prev = kb_interrupt;
    fe_prev = frame_error;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int glen);
    ps2data_ext = b;
    if (glen > 0) begin
      wait_cyc(10);
      ps2clk_ext = 1'b0;
      wait_cyc(glen);
      ps2clk_ext = 1'b1;
      wait_cyc(H - 10 - glen);
    end else begin
      wait_cyc(H);
    end
    ps2clk_ext = 1'b0;
    t_fall = cyc;
    wait_cyc(H);
    ps2clk_ext = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int gpos, input int glen);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i], (i == gpos) ? glen : 0);
    ps2data_ext = 1'b1;
  endtask

  // Byte-level protocol model: what a receiver should report for one frame.
  task automatic model(input logic [7:0] b, input bit valid);
    if (!valid) exp_err++;
    else if (kb_or_mouse) exp_q.push_back({b, 2'b00});
    else if (b == 8'hE0) ef = 1;
    else if (b == 8'hF0) rf = 1;
    else begin
      exp_q.push_back({b, rf, ef});
      ef = 0;
      rf = 0;
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_frame(b, bad_par, bad_stop, 11, -1, 0);
    model(b, !bad_par && !bad_stop);
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_nev"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_ev"}, act_q.pop_front(), exp_q.pop_front());
    act_q.delete();
    exp_q.delete();
    chk({tag, "_nerr"}, err_cnt, exp_err);
    exp_err = err_cnt;
  endtask

  initial begin
    int d;
    logic [7:0] b;
    bit bp, bs;
    rst_n = 1'b0; enable_rcv = 1'b1; kb_or_mouse = 1'b0;
    ps2clk_ext = 1'b1; ps2data_ext = 1'b1;
    wait_cyc(5);
    chk("rst_kb", kb_interrupt, 0);
    chk("rst_fe", frame_error, 0);
    chk("rst_code", scancode, 0);
    chk("rst_rel", released, 0);
    chk("rst_ext", extended, 0);
    rst_n = 1'b1;
    wait_cyc(20);

    frame(8'h1C, 0, 0); check_out("make1c");
    frame(8'hF0, 0, 0); check_out("f0_only");
    frame(8'h16, 0, 0); check_out("brk16");
    frame(8'hE0, 0, 0); frame(8'hF0, 0, 0); frame(8'h75, 0, 0); check_out("e0f0_75");
    frame(8'h75, 0, 0); check_out("plain75");
    frame(8'hF0, 0, 0); frame(8'hE0, 0, 0); frame(8'h6B, 0, 0); check_out("f0e0_6b");
    frame(8'h1C, 1, 0); check_out("badpar");
    frame(8'h1C, 0, 1); check_out("badstop");

    send_frame(8'h29, 0, 0, 5, -1, 0);
    wait_cyc(TO + 40);
    exp_err++;
    check_out("timeout");
    d = last_err_cyc - t_fall;
    chk("timeout_lat", (d >= TO + FL) && (d <= TO + FL + 5), 1);
    frame(8'h29, 0, 0); check_out("after_to");

    send_frame(8'h5A, 0, 0, 11, 3, FL - 1);
    model(8'h5A, 1);
    check_out("short_glitch");

    kb_or_mouse = 1'b1; ef = 0; rf = 0;
    frame(8'h08, 0, 0); frame(8'hF0, 0, 0); frame(8'hE0, 0, 0); check_out("mouse");

    send_frame(8'h3C, 0, 0, 11, 4, FL + 2);
    wait_cyc(TO + 50);
    chk("long_glitch", (act_q.size() + (err_cnt - exp_err)) > 0, 1);
    act_q.delete(); exp_q.delete(); exp_err = err_cnt;
    kb_or_mouse = 1'b0;
    frame(8'h66, 0, 0); check_out("after_glitch");

    frame(8'hE0, 0, 0);
    send_frame(8'h12, 0, 0, 5, -1, 0);
    enable_rcv = 1'b0; ef = 0; rf = 0;
    wait_cyc(20);
    enable_rcv = 1'b1;
    wait_cyc(TO + 40);
    check_out("en_drop");
    frame(8'h66, 0, 0); check_out("after_en");

    send_frame(8'h12, 0, 0, 5, -1, 0);
    rst_n = 1'b0; ef = 0; rf = 0;
    wait_cyc(3);
    rst_n = 1'b1;
    chk("midrst_code", scancode, 0);
    wait_cyc(TO + 40);
    check_out("mid_rst");
    frame(8'h66, 0, 0); check_out("after_rst");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        kb_or_mouse = 1'b1; ef = 0; rf = 0;
      end else begin
        kb_or_mouse = 1'b0;
      end
      case ($urandom_range(0, 3))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 15) == 0);
      frame(b, bp, bs);
      check_out("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 receive front end feeding the keyboard command decoder (the module that maps key releases to video mode and test triggers). It synchronises and deglitches the raw PS/2 clock and data lines, deframes 11-bit device-to-host frames, and checks odd parity. In keyboard mode it folds the E0/F0 prefixes into flags and emits one single-cycle event per complete make or break code. In mouse mode it emits every byte raw.

## Interface
- FILTER_LEN, 8: number of consecutive identical samples required before the filtered PS/2 clock changes level (2..16).
- TIMEOUT_CYCLES, 2000: idle-clock limit inside a frame, in clk cycles, before the frame is aborted.
- clk  input  1  system clock, 1–600 MHz; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable_rcv  input  1  1 = receiver active; 0 = FSM held in IDLE.
- kb_or_mouse  input  1  0 = keyboard (prefix decoding), 1 = mouse (raw bytes).
- ps2clk_ext  input  1  raw PS/2 clock pin, asynchronous.
- ps2data_ext  input  1  raw PS/2 data pin, asynchronous.
- kb_interrupt  output  1  one-cycle pulse: scancode/released/extended valid.
- scancode  output  8  received code byte, prefixes stripped.
- released  output  1  1 = break code (F0 seen).
- extended  output  1  1 = E0-prefixed code.
- frame_error  output  1  one-cycle pulse on a parity, start-bit, stop-bit or timeout error.

## Operation
- Input conditioning:
  - Each pin passes through 2 flops (sync1, sync2).
  - Clock filter: a counter tracks sync2. The filtered clock takes the new level once sync2 has differed from it for FILTER_LEN consecutive cycles; the counter clears whenever sync2 equals the filtered level.
  - Data is taken from sync2 with no filter.
- ps2_fall is a one-cycle strobe on each filtered 1→0 transition. All bit sampling happens on ps2_fall.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on ps2_fall with data=0 → DATA, bit counter=0. On ps2_fall with data=1 → frame_error, stay in IDLE.
  - DATA: shift data in LSB first; after the 8th bit → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: the byte is accepted if data=1 and XOR(8 data bits, parity bit)=1 (odd parity). Otherwise pulse frame_error and discard the byte. Return to IDLE in both cases.
- Timeout: a counter clears on every ps2_fall and increments in any non-IDLE state. When it reaches TIMEOUT_CYCLES-1: pulse frame_error, go to IDLE, drop the partial byte. Prefix flags are retained.
- Byte handling, keyboard mode (kb_or_mouse=0):
  - 0xE0: set ext_flag; no event.
  - 0xF0: set rel_flag; no event.
  - Any other byte: scancode←byte, released←rel_flag, extended←ext_flag, pulse kb_interrupt, clear both flags.
  - E1, FA, AA, EE, FE are emitted as ordinary codes.
  - Sequences F0 E0 xx and E0 F0 xx both emit released=1, extended=1.
- Byte handling, mouse mode (kb_or_mouse=1): every accepted byte is emitted with released=0 and extended=0. Flags are not set and are cleared.
- enable_rcv=0:
  - FSM is forced to IDLE and the timeout counter is cleared.
  - Prefix flags clear.
  - kb_interrupt and frame_error are held at 0.
  - Synchronisers and filter keep running, so re-enabling mid-frame does not produce a false edge.
- Reset (rst_n=0 at a clk edge):
  - kb_interrupt=0, frame_error=0, scancode=0x00, released=0, extended=0.
  - FSM=IDLE, flags=0, counters=0.
  - Filtered clock=1 and both synchroniser stages=1.
  - Reset mid-frame discards the frame with no error pulse.

## Timing
- Pin-to-ps2_fall latency: 2 (sync) + FILTER_LEN cycles, ±1 cycle for pin asynchrony.
- kb_interrupt and frame_error assert on the clk edge after the ps2_fall that samples the stop bit, are high for exactly 1 cycle, and are never both high in the same cycle.
- scancode, released and extended update on the same edge as kb_interrupt and hold until the next event.
- Glitches on ps2clk_ext shorter than FILTER_LEN cycles produce no edge.
- Back-to-back frames with zero idle between the stop bit and the next start bit are accepted.
- A ps2_fall in the same cycle as timeout expiry: the timeout wins and the bit is dropped.

## Test plan
- Reset → all outputs 0 and scancode=0x00. Frame 0x1C (parity 0): one kb_interrupt pulse, scancode=0x1C, released=0, extended=0, no frame_error.
- Frames F0, 16 → only one pulse, scancode=0x16, released=1, extended=0. Frames E0, F0, 75 → one pulse, scancode=0x75, released=1, extended=1. Flags clear afterwards, so a following 0x75 frame gives released=0, extended=0.
- Frame 0x1C sent with wrong parity → frame_error pulse, no kb_interrupt. Frame with stop=0 → frame_error. Frame abandoned after 5 bits → frame_error exactly TIMEOUT_CYCLES after the last edge; the next full 0x29 frame is decoded correctly.
- Glitches of FILTER_LEN-1 cycles injected on ps2clk_ext inside a 0x5A frame → scancode=0x5A with no error. A FILTER_LEN+2 cycle glitch → frame_error or a corrupted byte, never a hang.
- kb_or_mouse=1, bytes 08, F0, E0 → three pulses with scancode 08, F0, E0 and released=extended=0.
- enable_rcv dropped mid-frame then raised; rst_n asserted mid-frame → no pulses, and the next full frame 0x66 decodes correctly.
